// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants, state encodings and LFSR step for the pipe field
package pipe_pkg;

  localparam int DEF_SCREEN_W     = 640;
  localparam int DEF_PIPE_W       = 40;
  localparam int DEF_GAP_H        = 120;
  localparam int DEF_GAP_MIN      = 40;
  localparam int DEF_SPEED        = 2;
  localparam int DEF_PIPE_SPACING = 320;
  localparam int DEF_FLOOR_Y      = 480;
  localparam logic [7:0] DEF_LFSR_SEED = 8'hA5;

  // Gap top shown before the first game draws real openings
  localparam logic [9:0] GAP_RESET = 10'd160;

  localparam logic [2:0] QIdle   = 3'b001;
  localparam logic [2:0] QScroll = 3'b010;
  localparam logic [2:0] QCrash  = 3'b100;

  // Fibonacci LFSR step, taps 8,6,5,4
  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

endpackage

// File: rtl/pipe_lane.sv
// rtl/pipe_lane.sv - one scrolling pipe: position, opening and passed flag
module pipe_lane
  import pipe_pkg::*;
#(
  parameter int         PIPE_W  = DEF_PIPE_W,
  parameter int         GAP_H   = DEF_GAP_H,
  parameter int         SPEED   = DEF_SPEED,
  parameter logic [9:0] INIT_XR = 10'd680
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       reload,
  input  logic       move,
  input  logic [9:0] respawn_xr,
  input  logic       load_gap,
  input  logic [9:0] new_gap,
  input  logic [9:0] bird_x_l,
  input  logic [9:0] bird_x_r,
  input  logic [9:0] bird_y_t,
  input  logic [9:0] bird_y_b,
  output logic [9:0] xr,
  output logic [9:0] gap_top,
  output logic       wrap,
  output logic       hit,
  output logic       pass_evt
);

  localparam logic [9:0]  SPEED_V  = 10'(SPEED);
  localparam logic [9:0]  PIPE_W_V = 10'(PIPE_W);
  localparam logic [10:0] GAP_H_V  = 11'(GAP_H);

  logic       passed;
  logic [9:0] left;
  logic [9:0] moved;

  assign wrap  = (xr <= SPEED_V);
  assign moved = xr - SPEED_V;
  assign left  = (xr >= PIPE_W_V) ? (xr - PIPE_W_V) : 10'd0;

  assign hit = (bird_x_r > left) && (bird_x_l < xr) &&
               ((bird_y_t < gap_top) ||
                ({1'b0, bird_y_b} > ({1'b0, gap_top} + GAP_H_V)));

  // A pipe scores once per lap: the first move that puts its right edge left of the bird
  assign pass_evt = move && !wrap && !passed && (moved < bird_x_l);

  // Position and passed flag: reload in idle, scroll or respawn on a moving tick
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      xr     <= INIT_XR;
      passed <= 1'b0;
    end else if (reload) begin
      xr     <= INIT_XR;
      passed <= 1'b0;
    end else if (move) begin
      if (wrap) begin
        xr     <= respawn_xr;
        passed <= 1'b0;
      end else begin
        xr <= moved;
        if (pass_evt) passed <= 1'b1;
      end
    end
  end

  // Opening height, replaced whenever the top hands over a fresh draw
  always_ff @(posedge Clk or posedge reset) begin
    if (reset)         gap_top <= GAP_RESET;
    else if (load_gap) gap_top <= new_gap;
  end

endmodule

// File: rtl/pipe_field.sv
// rtl/pipe_field.sv - game FSM, gap randomiser, respawn arbitration and score
module pipe_field
  import pipe_pkg::*;
#(
  parameter int         SCREEN_W     = DEF_SCREEN_W,
  parameter int         PIPE_W       = DEF_PIPE_W,
  parameter int         GAP_H        = DEF_GAP_H,
  parameter int         GAP_MIN      = DEF_GAP_MIN,
  parameter int         SPEED        = DEF_SPEED,
  parameter int         PIPE_SPACING = DEF_PIPE_SPACING,
  parameter int         FLOOR_Y      = DEF_FLOOR_Y,
  parameter logic [7:0] LFSR_SEED    = DEF_LFSR_SEED
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       Start,
  input  logic       Ack,
  input  logic       Tick,
  input  logic [9:0] Bird_X_L,
  input  logic [9:0] Bird_X_R,
  input  logic [9:0] Bird_Y_T,
  input  logic [9:0] Bird_Y_B,
  output logic [9:0] Pipe0_XR,
  output logic [9:0] Pipe1_XR,
  output logic [9:0] Pipe0_GapTop,
  output logic [9:0] Pipe1_GapTop,
  output logic       Stop,
  output logic [7:0] Score,
  output logic       q_Idle,
  output logic       q_Scroll,
  output logic       q_Crash
);

  // Pipe 0 starts just off the right edge, pipe 1 one spacing further out
  localparam logic [9:0] INIT0     = 10'(SCREEN_W + PIPE_W);
  localparam logic [9:0] INIT1     = 10'(SCREEN_W + PIPE_W + PIPE_SPACING);
  localparam logic [9:0] GAP_MIN_V = 10'(GAP_MIN);
  localparam logic [9:0] SPACING_V = 10'(PIPE_SPACING);
  localparam logic [9:0] FLOOR_V   = 10'(FLOOR_Y);

  logic [2:0] state, state_nxt;
  logic [7:0] lfsr, lfsr1;
  logic       in_idle, in_scroll, in_crash;
  logic       start_go, hit_any, mv, floor_hit;
  logic       hit0, hit1, wrap0, wrap1, evt0, evt1;
  logic       load0, load1;
  logic [9:0] gap0_new, gap1_new;
  logic [8:0] score_sum;

  assign in_idle   = (state == QIdle);
  assign in_scroll = (state == QScroll);
  assign in_crash  = (state == QCrash);
  assign {q_Crash, q_Scroll, q_Idle} = state;
  assign Stop      = q_Crash;

  assign floor_hit = (Bird_Y_B >= FLOOR_V);
  assign hit_any   = in_scroll && (hit0 || hit1 || floor_hit);
  assign start_go  = in_idle && Start;
  // A colliding cycle never moves the field, even with Tick present
  assign mv        = in_scroll && Tick && !hit_any;

  // Pipe 0 consumes the current LFSR value first; pipe 1 takes the next one if both draw
  assign load0    = start_go || (mv && wrap0);
  assign load1    = start_go || (mv && wrap1);
  assign lfsr1    = lfsr_next(lfsr);
  assign gap0_new = GAP_MIN_V + {2'b00, lfsr};
  assign gap1_new = GAP_MIN_V + {2'b00, (load0 ? lfsr1 : lfsr)};

  assign score_sum = {1'b0, Score} + {8'd0, evt0} + {8'd0, evt1};

  pipe_lane #(.PIPE_W(PIPE_W), .GAP_H(GAP_H), .SPEED(SPEED), .INIT_XR(INIT0)) u_lane0 (
    .Clk(Clk), .reset(reset), .reload(in_idle), .move(mv),
    .respawn_xr(Pipe1_XR + SPACING_V), .load_gap(load0), .new_gap(gap0_new),
    .bird_x_l(Bird_X_L), .bird_x_r(Bird_X_R), .bird_y_t(Bird_Y_T), .bird_y_b(Bird_Y_B),
    .xr(Pipe0_XR), .gap_top(Pipe0_GapTop), .wrap(wrap0), .hit(hit0), .pass_evt(evt0)
  );

  pipe_lane #(.PIPE_W(PIPE_W), .GAP_H(GAP_H), .SPEED(SPEED), .INIT_XR(INIT1)) u_lane1 (
    .Clk(Clk), .reset(reset), .reload(in_idle), .move(mv),
    .respawn_xr(Pipe0_XR + SPACING_V), .load_gap(load1), .new_gap(gap1_new),
    .bird_x_l(Bird_X_L), .bird_x_r(Bird_X_R), .bird_y_t(Bird_Y_T), .bird_y_b(Bird_Y_B),
    .xr(Pipe1_XR), .gap_top(Pipe1_GapTop), .wrap(wrap1), .hit(hit1), .pass_evt(evt1)
  );

  // Next-state: Start leaves idle, any hit ends flight, Ack clears a crash
  always_comb begin
    state_nxt = state;
    case (state)
      QIdle:   if (Start)   state_nxt = QScroll;
      QScroll: if (hit_any) state_nxt = QCrash;
      QCrash:  if (Ack)     state_nxt = QIdle;
      default:              state_nxt = QIdle;
    endcase
  end

  // State register
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) state <= QIdle;
    else       state <= state_nxt;
  end

  // LFSR advances once per gap drawn; Ack leaves it alone so games differ
  always_ff @(posedge Clk or posedge reset) begin
    if (reset)               lfsr <= LFSR_SEED;
    else if (load0 && load1) lfsr <= lfsr_next(lfsr1);
    else if (load0 || load1) lfsr <= lfsr1;
  end

  // Score clears on Start, accumulates passes on moving ticks, saturates at 255
  always_ff @(posedge Clk or posedge reset) begin
    if (reset)         Score <= 8'd0;
    else if (start_go) Score <= 8'd0;
    else if (mv && !in_crash) Score <= score_sum[8] ? 8'hFF : score_sum[7:0];
  end

endmodule

// File: tb/tb_pipe_field.sv
// tb/tb_pipe_field.sv - scoreboard bench for pipe_field
module tb_pipe_field;

  logic       Clk = 1'b0;
  logic       reset = 1'b1;
  logic       Start = 1'b0, Ack = 1'b0, Tick = 1'b0;
  logic [9:0] Bird_X_L = 10'd300, Bird_X_R = 10'd320;
  logic [9:0] Bird_Y_T = 10'd220, Bird_Y_B = 10'd240;
  logic [9:0] Pipe0_XR, Pipe1_XR, Pipe0_GapTop, Pipe1_GapTop;
  logic       Stop, q_Idle, q_Scroll, q_Crash;
  logic [7:0] Score;

  pipe_field dut (
    .Clk(Clk), .reset(reset), .Start(Start), .Ack(Ack), .Tick(Tick),
    .Bird_X_L(Bird_X_L), .Bird_X_R(Bird_X_R), .Bird_Y_T(Bird_Y_T), .Bird_Y_B(Bird_Y_B),
    .Pipe0_XR(Pipe0_XR), .Pipe1_XR(Pipe1_XR),
    .Pipe0_GapTop(Pipe0_GapTop), .Pipe1_GapTop(Pipe1_GapTop),
    .Stop(Stop), .Score(Score),
    .q_Idle(q_Idle), .q_Scroll(q_Scroll), .q_Crash(q_Crash)
  );

  always #5 Clk = ~Clk;

  localparam int S_XR0 = 0, S_XR1 = 1, S_G0 = 2, S_G1 = 3, S_STOP = 4;
  localparam int S_SCORE = 5, S_IDLE = 6, S_SCROLL = 7, S_CRASH = 8;

  typedef struct {
    int    cyc;
    int    sel;
    int    exp;
    string name;
  } exp_t;

  exp_t  sbq[$];
  exp_t  mon_e;
  int    cyc = 0;
  int    n_cmp = 0;
  int    n_bad = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  function automatic int actual(input int sel);
    case (sel)
      S_XR0:    return int'(Pipe0_XR);
      S_XR1:    return int'(Pipe1_XR);
      S_G0:     return int'(Pipe0_GapTop);
      S_G1:     return int'(Pipe1_GapTop);
      S_STOP:   return int'(Stop);
      S_SCORE:  return int'(Score);
      S_IDLE:   return int'(q_Idle);
      S_SCROLL: return int'(q_Scroll);
      default:  return int'(q_Crash);
    endcase
  endfunction

  // Monitor: compare every expectation due by this cycle on the falling edge
  always @(negedge Clk) begin
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      mon_e = sbq.pop_front();
      n_cmp = n_cmp + 1;
      if (actual(mon_e.sel) != mon_e.exp) begin
        n_bad = n_bad + 1;
        $display("FAIL %s: got %0d expected %0d (cycle %0d)", mon_e.name,
                 actual(mon_e.sel), mon_e.exp, cyc);
      end
    end
  end

  task automatic expect_v(input string nm, input int sel, input int e);
    exp_t x;
    x.cyc = cyc; x.sel = sel; x.exp = e; x.name = nm;
    sbq.push_back(x);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic tick1();
    Tick = 1'b1;
    step(1);
    Tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick1();
      step(3);
    end
  endtask

  task automatic start_game();
    Start = 1'b1;
    step(1);
    Start = 1'b0;
  endtask

  initial begin
    // Reset and idle
    step(2);
    reset = 1'b0;
    step(1);
    expect_v("rst_xr0", S_XR0, 680);
    expect_v("rst_xr1", S_XR1, 1000);
    expect_v("rst_g0", S_G0, 160);
    expect_v("rst_g1", S_G1, 160);
    expect_v("rst_score", S_SCORE, 0);
    expect_v("rst_stop", S_STOP, 0);
    expect_v("rst_idle", S_IDLE, 1);
    Ack = 1'b1; Tick = 1'b1;
    step(1);
    Ack = 1'b0; Tick = 1'b0;
    step(1);
    expect_v("idle_ack_tick_state", S_IDLE, 1);
    expect_v("idle_ack_tick_xr0", S_XR0, 680);

    // Clean pass through pipe 0
    start_game();
    expect_v("start_g0", S_G0, 205);
    expect_v("start_g1", S_G1, 114);
    expect_v("start_scroll", S_SCROLL, 1);
    expect_v("start_xr0", S_XR0, 680);
    ticks(161);
    expect_v("t161_xr0", S_XR0, 358);
    expect_v("t161_stop", S_STOP, 0);
    ticks(29);
    expect_v("t190_xr0", S_XR0, 300);
    expect_v("t190_score", S_SCORE, 0);
    ticks(1);
    expect_v("t191_xr0", S_XR0, 298);
    expect_v("t191_score", S_SCORE, 1);
    Bird_Y_T = 10'd210; Bird_Y_B = 10'd230;
    ticks(148);
    expect_v("t339_xr0", S_XR0, 2);
    expect_v("t339_xr1", S_XR1, 322);
    ticks(1);
    expect_v("respawn_xr0", S_XR0, 642);
    expect_v("respawn_g0", S_G0, 189);
    expect_v("respawn_xr1", S_XR1, 320);
    ticks(11);
    expect_v("t351_score", S_SCORE, 2);
    expect_v("t351_xr1", S_XR1, 298);
    ticks(161);
    expect_v("t512_score", S_SCORE, 3);
    expect_v("t512_xr0", S_XR0, 298);
    expect_v("t512_xr1", S_XR1, 620);
    expect_v("t512_g1", S_G1, 82);

    // Floor hit without Tick, then crash ignores Tick and Start
    Bird_Y_T = 10'd470; Bird_Y_B = 10'd480;
    step(1);
    expect_v("floor_stop", S_STOP, 1);
    expect_v("floor_crash", S_CRASH, 1);
    Tick = 1'b1; Start = 1'b1;
    step(1);
    Tick = 1'b0; Start = 1'b0;
    expect_v("crash_frozen_xr0", S_XR0, 298);
    expect_v("crash_ignore_start", S_CRASH, 1);
    Ack = 1'b1;
    step(1);
    Ack = 1'b0;
    step(1);
    expect_v("ack_idle", S_IDLE, 1);
    expect_v("ack_score_held", S_SCORE, 3);
    expect_v("idle_reload_xr0", S_XR0, 680);
    expect_v("idle_reload_xr1", S_XR1, 1000);

    // Pipe hit; LFSR carries over from the previous game
    Bird_Y_T = 10'd100; Bird_Y_B = 10'd120;
    start_game();
    expect_v("g2_g0", S_G0, 124);
    expect_v("g2_g1", S_G1, 209);
    expect_v("g2_score_clr", S_SCORE, 0);
    ticks(160);
    tick1();
    expect_v("hit_xr0", S_XR0, 358);
    expect_v("hit_stop_pre", S_STOP, 0);
    tick1();
    expect_v("hit_stop", S_STOP, 1);
    expect_v("hit_crash", S_CRASH, 1);
    expect_v("hit_crash_wins", S_XR0, 358);
    ticks(3);
    expect_v("hit_frozen", S_XR0, 358);
    Ack = 1'b1;
    step(1);
    Ack = 1'b0;
    expect_v("hit_ack_idle", S_IDLE, 1);
    expect_v("hit_ack_score", S_SCORE, 0);

    // Asynchronous reset in the middle of SCROLL
    Bird_Y_T = 10'd220; Bird_Y_B = 10'd240;
    start_game();
    ticks(5);
    expect_v("pre_rst_xr0", S_XR0, 670);
    step(1);
    #2;
    reset = 1'b1;
    #1;
    expect_v("arst_xr0", S_XR0, 680);
    expect_v("arst_xr1", S_XR1, 1000);
    expect_v("arst_g0", S_G0, 160);
    expect_v("arst_idle", S_IDLE, 1);
    expect_v("arst_scroll", S_SCROLL, 0);
    step(1);
    reset = 1'b0;
    step(1);

    // Saturation: bird far right, every pipe counts once per lap
    Bird_X_L = 10'd1010; Bird_X_R = 10'd1020;
    Bird_Y_T = 10'd200;  Bird_Y_B = 10'd210;
    start_game();
    Tick = 1'b1;
    step(1);
    expect_v("double_pass", S_SCORE, 2);
    step(41500);
    Tick = 1'b0;
    expect_v("sat_score", S_SCORE, 255);
    expect_v("sat_scroll", S_SCROLL, 1);

    step(3);
    if (sbq.size() != 0) begin
      n_bad = n_bad + sbq.size();
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
